// File: rtl/pixel_loader_pkg.sv
// pixel_loader_pkg: shared MNIST dimensions and the pixel quantisation rule.
package pixel_loader_pkg;
    localparam int MNIST_N_PIX = 784;
    localparam int PIX_W = 8;
    localparam int FC1_IN = MNIST_N_PIX;
    localparam int FC1_OUT = 128;
    localparam int FC2_OUT = 10;
    function automatic logic [PIX_W-1:0] quantise(input logic [PIX_W-1:0] d, input int shift);
        logic [PIX_W-1:0] q;
        q = d >> shift;
        return q > 8'd127 ? 8'd127 : q;
    endfunction
endpackage

// File: rtl/pixel_loader_if.sv
// pixel_loader_if: byte stream in, image-buffer writes and frame handshake out.
interface pixel_loader_if import pixel_loader_pkg::*; #(parameter int N_PIX = MNIST_N_PIX);
    localparam int AW = $clog2(N_PIX);
    logic s_valid;
    logic s_ready;
    logic [PIX_W-1:0] s_data;
    logic x_we;
    logic [AW-1:0] x_addr;
    logic signed [PIX_W-1:0] x_data;
    logic start;
    logic infer_done;
    logic [15:0] frame_cnt;
    logic err_timeout;
    modport master (
        output s_valid, s_data, infer_done,
        input s_ready, x_we, x_addr, x_data, start, frame_cnt, err_timeout
    );
    modport slave (
        input s_valid, s_data, infer_done,
        output s_ready, x_we, x_addr, x_data, start, frame_cnt, err_timeout
    );
endinterface

// File: rtl/pixel_loader_idle_timer.sv
// pixel_loader_idle_timer: counts enabled idle cycles, flags the TIMEOUT-th one.
module pixel_loader_idle_timer #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    logic [W-1:0] cnt;
    assign expire = TIMEOUT != 0 && enable && !clear && cnt == W'(TIMEOUT - 1);
    always_ff @(posedge clk)
        if (rst || clear || expire) cnt <= '0;
        else if (enable) cnt <= cnt + W'(1);
endmodule

// File: rtl/pixel_loader.sv
// pixel_loader: streams uint8 pixels into the image buffer and hands complete frames to the FC layers.
module pixel_loader import pixel_loader_pkg::*; #(
    parameter int N_PIX = MNIST_N_PIX,
    parameter int PIX_SHIFT = 1,
    parameter int TIMEOUT = 1000000
) (
    input logic clk,
    input logic rst,
    pixel_loader_if.slave bus
);
    localparam int AW = $clog2(N_PIX);
    localparam logic [1:0] S_LOAD = 2'd0, S_START = 2'd1, S_WAIT = 2'd2;
    logic [1:0] state, next;
    logic [AW-1:0] pix_cnt;
    logic accept, last, expire;
    assign bus.s_ready = state == S_LOAD && !rst;
    assign accept = bus.s_valid && bus.s_ready;
    assign last = pix_cnt == AW'(N_PIX - 1);
    always_comb
        next = state == S_LOAD ? (accept && last ? S_START : S_LOAD) :
               state == S_START ? S_WAIT :
               state == S_WAIT ? (bus.infer_done ? S_LOAD : S_WAIT) : S_LOAD;
    // Timer only runs mid-frame; a byte in the expiry cycle clears it and wins.
    pixel_loader_idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(clk),
        .rst(rst),
        .clear(accept || pix_cnt == '0 || state != S_LOAD),
        .enable(state == S_LOAD),
        .expire(expire)
    );
    always_ff @(posedge clk)
        if (rst) begin
            state <= S_LOAD;
            pix_cnt <= '0;
            bus.x_we <= 1'b0;
            bus.x_addr <= '0;
            bus.x_data <= '0;
            bus.start <= 1'b0;
            bus.err_timeout <= 1'b0;
            bus.frame_cnt <= '0;
        end else begin
            state <= next;
            bus.x_we <= accept;
            if (accept) begin
                bus.x_addr <= pix_cnt;
                bus.x_data <= $signed(quantise(bus.s_data, PIX_SHIFT));
            end
            bus.start <= state == S_START;
            bus.err_timeout <= expire;
            if (state == S_START) bus.frame_cnt <= bus.frame_cnt + 16'd1;
            pix_cnt <= accept ? (last ? '0 : pix_cnt + AW'(1)) : expire ? '0 : pix_cnt;
        end
endmodule

// File: tb/tb_pixel_loader.sv
// tb_pixel_loader: directed and random frames checked against a frame-level reference model.
module tb_pixel_loader;
    import pixel_loader_pkg::*;
    localparam int NP = 784, SH = 1, TO = 16;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;
    pixel_loader_if #(.N_PIX(NP)) a();
    pixel_loader_if #(.N_PIX(4)) b();
    pixel_loader #(.N_PIX(NP), .PIX_SHIFT(SH), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(a.slave));
    pixel_loader #(.N_PIX(4), .PIX_SHIFT(0), .TIMEOUT(0)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));
    int total = 0, bad = 0;
    int m_cnt, m_phase, m_idle, m_frames, n_start, n_err;
    int n0, tgt, b_err;
    logic [7:0] bd [4];
    int be [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qref(input int d, input int sh);
        int q;
        q = d >> sh;
        return q > 127 ? 127 : q;
    endfunction

    // Model: phase 0 collecting, 1 frame just completed, 2 waiting for infer_done.
    task automatic cyc(input logic v, input logic [7:0] d, input logic inf);
        logic acc, e_start, e_err;
        a.s_valid = v;
        a.s_data = d;
        a.infer_done = inf;
        #1 chk("s_ready", a.s_ready, m_phase == 0);
        acc = v && m_phase == 0;
        @(posedge clk);
        #1;
        e_start = m_phase == 1;
        e_err = 0;
        if (m_phase == 1) m_phase = 2;
        else if (m_phase == 2) m_phase = inf ? 0 : 2;
        else if (acc) begin
            chk("x_addr", a.x_addr, m_cnt);
            chk("x_data", $unsigned(a.x_data), qref(d, SH));
            m_idle = 0;
            m_cnt++;
            if (m_cnt == NP) begin
                m_cnt = 0;
                m_phase = 1;
            end
        end else if (m_cnt > 0) begin
            m_idle++;
            if (m_idle == TO) begin
                m_idle = 0;
                m_cnt = 0;
                e_err = 1;
            end
        end
        if (e_start) m_frames = (m_frames + 1) % 65536;
        chk("x_we", a.x_we, acc);
        chk("start", a.start, e_start);
        chk("err_timeout", a.err_timeout, e_err);
        chk("frame_cnt", a.frame_cnt, m_frames);
        n_start += int'(a.start);
        n_err += int'(a.err_timeout);
    endtask

    task automatic do_reset();
        rst = 1;
        a.s_valid = 0; a.s_data = 0; a.infer_done = 0;
        b.s_valid = 0; b.s_data = 0; b.infer_done = 0;
        #1 chk("rst_ready_comb", a.s_ready, 0);
        @(posedge clk);
        #1;
        chk("rst_ready", a.s_ready, 0);
        chk("rst_we", a.x_we, 0);
        chk("rst_addr", a.x_addr, 0);
        chk("rst_data", $unsigned(a.x_data), 0);
        chk("rst_start", a.start, 0);
        chk("rst_err", a.err_timeout, 0);
        chk("rst_frame_cnt", a.frame_cnt, 0);
        chk("rst_b_frame_cnt", b.frame_cnt, 0);
        rst = 0;
        m_cnt = 0; m_phase = 0; m_idle = 0; m_frames = 0;
    endtask

    initial begin
        n_start = 0;
        n_err = 0;
        do_reset();
        // Saturation with PIX_SHIFT=0 and a long mid-frame stall with TIMEOUT=0.
        bd = '{8'hFF, 8'h80, 8'h00, 8'h7F};
        be = '{127, 127, 0, 127};
        b_err = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                b.s_valid = 0;
                repeat (40) begin
                    @(posedge clk);
                    #1 b_err += int'(b.err_timeout);
                end
            end
            b.s_valid = 1;
            b.s_data = bd[i];
            @(posedge clk);
            #1;
            chk("b_we", b.x_we, 1);
            chk("b_addr", b.x_addr, i);
            chk("b_data", $unsigned(b.x_data), be[i]);
        end
        b.s_valid = 0;
        @(posedge clk);
        #1;
        chk("b_start", b.start, 1);
        chk("b_frame_cnt", b.frame_cnt, 1);
        chk("b_no_timeout", b_err, 0);
        // Full frame, data = addr mod 256.
        for (int i = 0; i < NP; i++) cyc(1, 8'(i % 256), 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("frame1_starts", n_start, 1);
        chk("frame1_cnt", a.frame_cnt, 1);
        // Back-pressure while waiting, then release.
        repeat (50) cyc(1, 8'($urandom), 0);
        cyc(0, 0, 1);
        cyc(1, 8'd200, 0);
        chk("addr0_after_wait", a.x_addr, 0);
        // Mid-frame stall longer than TIMEOUT.
        n0 = n_err;
        for (int i = 0; i < 10; i++) cyc(1, 8'($urandom), 0);
        repeat (20) cyc(0, 0, 0);
        chk("one_timeout", n_err - n0, 1);
        cyc(1, 8'd7, 0);
        chk("addr0_after_timeout", a.x_addr, 0);
        for (int i = 1; i < NP; i++) cyc(1, 8'($urandom), 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("frame2_cnt", a.frame_cnt, 2);
        cyc(0, 0, 1);
        // Byte arriving exactly in the expiry cycle.
        n0 = n_err;
        for (int i = 0; i < 5; i++) cyc(1, 8'($urandom), 0);
        repeat (TO - 1) cyc(0, 0, 0);
        cyc(1, 8'd33, 0);
        chk("expiry_byte_addr", a.x_addr, 5);
        chk("expiry_no_timeout", n_err - n0, 0);
        // Reset mid-frame discards it.
        do_reset();
        n0 = n_start;
        for (int i = 0; i < 400; i++) cyc(1, 8'($urandom), 0);
        do_reset();
        chk("mid_reset_starts", n_start - n0, 0);
        for (int i = 0; i < NP; i++) cyc(1, 8'($urandom), 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("post_reset_starts", n_start - n0, 1);
        chk("post_reset_cnt", a.frame_cnt, 1);
        cyc(0, 0, 1);
        // Random traffic: gaps, occasional long stalls, stray infer_done.
        for (int f = 0; f < 3; f++) begin
            tgt = int'(a.frame_cnt) + 1;
            for (int k = 0; k < 8000 && int'(a.frame_cnt) != tgt; k++) begin
                if ($urandom_range(0, 2999) == 0) repeat (20) cyc(0, 0, 0);
                cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0);
            end
            chk("rand_frame", a.frame_cnt, tgt);
            cyc(0, 0, 0);
            cyc(0, 0, 1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pixel_loader.md
PIXEL_LOADER -- requirements
Module: pixel_loader

Interface
REQ-001 Parameter N_PIX, default 784: pixels per frame.
REQ-002 Parameter PIX_SHIFT, default 1: right-shift applied to each uint8 pixel.
REQ-003 Parameter TIMEOUT, default 1000000: idle cycles mid-frame before abort; 0 disables.
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 s_valid  input  1  upstream byte valid.
REQ-007 s_ready  output  1  loader can accept a byte.
REQ-008 s_data  input  8  unsigned pixel, row-major order.
REQ-009 x_we  output  1  image-buffer write enable.
REQ-010 x_addr  output  $clog2(N_PIX)  image-buffer write address.
REQ-011 x_data  output  8 signed  quantised pixel.
REQ-012 start  output  1  one-cycle pulse to first FC layer: image complete.
REQ-013 infer_done  input  1  one-cycle pulse from inference controller: image buffer free.
REQ-014 frame_cnt  output  16  completed frames, wraps at 65535 -> 0.
REQ-015 err_timeout  output  1  one-cycle pulse on mid-frame abort.

Function
REQ-016 Byte accepted in a cycle only when s_valid && s_ready.
REQ-017 States: S_LOAD, S_START, S_WAIT; state after reset is S_LOAD.
REQ-018 s_ready = 1 only in S_LOAD and rst low; combinational from state.
REQ-019 Pixel counter pix_cnt starts at 0, increments per accepted byte.
REQ-020 Write latency 1: byte accepted at cycle t -> x_we=1, x_addr=pix_cnt at t, x_data at t+1; x_we=0 otherwise.
REQ-021 Quantisation: q = s_data >> PIX_SHIFT, zero-extended; q > 127 saturates to 127; x_data never negative.
REQ-022 Byte accepted with pix_cnt = N_PIX-1 -> pix_cnt <= 0, state <= S_START; s_ready low from t+1.
REQ-023 S_START lasts one cycle (t+1, last write occurs); start=1 registered in cycle t+2; state S_WAIT from t+2.
REQ-024 frame_cnt increments in the cycle start is asserted.
REQ-025 S_WAIT: s_ready=0; infer_done=1 -> S_LOAD next cycle.
REQ-026 infer_done ignored in S_LOAD and S_START.
REQ-027 Idle timer: clears on every accepted byte and whenever pix_cnt=0 or state != S_LOAD; increments otherwise.
REQ-028 Timer reaches TIMEOUT-1 with no byte accepted that cycle -> pix_cnt <= 0, err_timeout=1 next cycle, state stays S_LOAD; no x_we.
REQ-029 Byte accepted in the timeout cycle -> byte wins, no abort, timer clears.
REQ-030 TIMEOUT=0 -> err_timeout never asserts.
REQ-031 start and err_timeout never high together; at most one start per infer_done.

Reset
REQ-032 rst high at a clock edge -> state S_LOAD, pix_cnt 0, timer 0, x_we 0, x_addr 0, x_data 0, start 0, err_timeout 0, frame_cnt 0.
REQ-033 Reset mid-frame or in S_WAIT discards partial frame; no start issued for it.
REQ-034 s_ready=0 while rst high; 1 in the first cycle after rst falls.

Structure
REQ-035 N_PIX, pixel width (8), FC dimensions: shared MNIST parameter include used by the top level and both FC layers; state encodings local.
REQ-036 One sub-module natural: idle_timer (clear, enable, TIMEOUT param, expire output); rest flat.
REQ-037 Outputs driven from registers except s_ready.

Verification
REQ-038 784 bytes, s_valid held 1, data = addr mod 256 -> 784 writes, x_data = (addr mod 256)>>1, addr 0..783 in order; start one cycle, two cycles after last accept; frame_cnt=1.
REQ-039 s_data=0xFF, PIX_SHIFT=0 -> x_data=127; 0x80, PIX_SHIFT=1 -> 64; 0x00 -> 0.
REQ-040 After start, s_valid held 1 for 50 cycles -> s_ready 0, no x_we; infer_done pulse -> s_ready 1 next cycle, next byte written at addr 0.
REQ-041 TIMEOUT=16, 10 bytes then s_valid low 20 cycles -> one err_timeout pulse; next 784 bytes form a full frame from addr 0.
REQ-042 TIMEOUT=16, byte arrives exactly on expiry cycle -> no err_timeout, byte written at next address.
REQ-043 rst for one cycle after 400 bytes -> no start, frame_cnt 0; following 784 bytes -> one start, frame_cnt 1.
